window_integrator: RTL and testbench
====================================

Name: window_integrator

Overview:
- Consumes the pixel stream produced by the data fetcher: one FEATURE_WIDTH x FEATURE_HEIGHT window at a time, raster order, tagged with a 2-bit eot.
- For every pixel, emits the window-local integral image value and the squared integral image value.
- Feeds the feature evaluator and the variance-normalisation stage.
- Fully pipelined at one pixel per clock when unstalled; 1-cycle latency.

Parameters:
- W_DATA, 8, pixel width.
- FEATURE_WIDTH, 24, window width in pixels.
- FEATURE_HEIGHT, 24, window height in pixels.
- W_II (localparam), W_DATA+$clog2(FEATURE_WIDTH*FEATURE_HEIGHT), integral width.
- W_SQII (localparam), 2*W_DATA+$clog2(FEATURE_WIDTH*FEATURE_HEIGHT), squared-integral width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- din_valid  in  1  pixel valid.
- din_ready  out  1  pixel accepted when valid&ready.
- din_data  in  W_DATA  pixel.
- din_eot  in  2  bit0 = last pixel of row, bit1 = last pixel of window (bit1 implies bit0).
- dout_valid  out  1  result valid.
- dout_ready  in  1  downstream ready.
- dout_ii  out  W_II  integral value at (x,y).
- dout_sqii  out  W_SQII  squared integral value at (x,y).
- dout_eot  out  2  din_eot delayed with its pixel.
- err  out  1  sticky framing error.

Behaviour:
- Reset (rst low, asynchronous):
  - dout_valid, dout_ii, dout_sqii, dout_eot, err = 0.
  - Column counter = 0, row counter = 0, first_row = 1.
  - Row accumulators = 0; row buffer contents are don't-care because first_row masks them.
- Handshake:
  - din_ready = !dout_valid | dout_ready (combinational).
  - On din accept, the output register loads the new result and dout_valid = 1 on the next cycle.
  - If dout_valid & dout_ready and there is no accept, dout_valid falls to 0.
  - Output is stable while dout_valid & !dout_ready.
- Arithmetic on accept of pixel p at column x:
  - rs = rowsum + p.
  - rq = rowsq + p*p.
  - ii = rs + (first_row ? 0 : buf_ii[x]).
  - sq = rq + (first_row ? 0 : buf_sq[x]).
  - All arithmetic is unsigned and zero-extended to W_II/W_SQII; the widths are sized so nothing overflows.
  - Then write buf_ii[x] = ii and buf_sq[x] = sq; the read precedes the write for the same x in the same cycle.
- Counters:
  - Column advances on each accept.
  - On eot[0]: column resets to 0, rowsum/rowsq clear to 0, first_row = 0.
  - On eot[1]: column and row reset to 0, first_row = 1, accumulators clear.
- Framing checks:
  - eot[0] with column != FEATURE_WIDTH-1 sets err.
  - Column == FEATURE_WIDTH-1 without eot[0] sets err.
  - eot[1] with row != FEATURE_HEIGHT-1 sets err.
  - On any of these, the counters still resynchronise to the eot or wrap the column at FEATURE_WIDTH.
  - err clears only on reset.
- No stall of the accumulators occurs without an accept; a din_valid held without ready changes nothing.
- Back-to-back windows are allowed with zero bubble: the first pixel of window N+1 can be accepted the cycle after the eot[1] of window N.
- States: FIRST_ROW and OTHER_ROWS, encoded by first_row. Transitions are FIRST_ROW→OTHER_ROWS on eot[0]&!eot[1], and any→FIRST_ROW on eot[1].

Decomposition:
- Package classifier_pkg holds:
  - the constants EOT_ROW=0 and EOT_WIN=1;
  - the functions that compute W_II/W_SQII from the window dimensions;
  - typedefs ii_t and sqii_t.
- Sub-module ii_row_buffer: a FEATURE_WIDTH-entry register array with one read port and one write port at the same index, storing the {ii, sqii} pair. This keeps the top at about 150 lines.

Test Plan:
- All pixels = 1, 24x24 window, dout_ready = 1 → dout_ii at (x,y) = (x+1)(y+1), last value 576, dout_sqii last = 576, dout_eot = 2'b11 on the 576th output, err = 0.
- All pixels = 255 → last dout_ii = 146880 and last dout_sqii = 37454400; no overflow in 18/26 bits.
- Ramp p = x+y → every output matches a software integral model; dout_eot bit0 appears every 24 outputs.
- Random dout_ready (50%) and random din_valid gaps → output sequence identical to the unstalled run; dout_data is stable while dout_valid & !dout_ready.
- Two back-to-back windows of value 2 then 3 → the second window's first output = 3, with no contamination from window 1's row buffer.
- eot[0] injected at column 10 → err = 1 next cycle, the column restarts at 0, and the following row sums restart.
- Reset asserted mid-window → outputs are 0 immediately; a fresh window after release produces correct values.

Source files
------------

// File: rtl/classifier_pkg.sv
// Shared constants, width helpers and types for the integral-image front end.
package classifier_pkg;

   // Bit positions inside the 2-bit end-of-transfer tag.
   localparam int EOT_ROW = 0;
   localparam int EOT_WIN = 1;

   // Integral width: enough headroom to sum every pixel of one window.
   function automatic int calc_w_ii(input int w_data, input int fw, input int fh);
      return w_data + $clog2(fw * fh);
   endfunction

   // Squared-integral width: squared pixels summed over one window.
   function automatic int calc_w_sqii(input int w_data, input int fw, input int fh);
      return 2 * w_data + $clog2(fw * fh);
   endfunction

   localparam int W_II_DEF   = calc_w_ii(8, 24, 24);
   localparam int W_SQII_DEF = calc_w_sqii(8, 24, 24);

   typedef logic [W_II_DEF-1:0]   ii_t;
   typedef logic [W_SQII_DEF-1:0] sqii_t;

   // Row state of the integrator; the encoding doubles as the first_row flag.
   typedef enum logic {
      OTHER_ROWS = 1'b0,
      FIRST_ROW  = 1'b1
   } row_state_e;

endpackage

// File: rtl/ii_row_buffer.sv
// One-row store of {ii, sqii} per column. Combinational read and registered
// write share one index, so a same-cycle read sees the previous row's value.
module ii_row_buffer
   import classifier_pkg::*;
#(
   parameter int DEPTH  = 24,
   parameter int W_II   = 18,
   parameter int W_SQII = 26,
   localparam int W_IDX = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic [W_IDX-1:0]  idx,
   input  logic              we,
   input  logic [W_II-1:0]   wr_ii,
   input  logic [W_SQII-1:0] wr_sq,
   output logic [W_II-1:0]   rd_ii,
   output logic [W_SQII-1:0] rd_sq
);

   logic [W_II+W_SQII-1:0] mem [DEPTH];

   assign {rd_ii, rd_sq} = mem[idx];

   // Contents need no reset: the first row of every window ignores them.
   always_ff @(posedge clk) begin
      if (we) mem[idx] <= {wr_ii, wr_sq};
   end

endmodule

// File: rtl/window_integrator.sv
// Window-local integral and squared-integral image, one pixel per clock,
// single output register with valid/ready, sticky framing error.
module window_integrator
   import classifier_pkg::*;
#(
   parameter int W_DATA         = 8,
   parameter int FEATURE_WIDTH  = 24,
   parameter int FEATURE_HEIGHT = 24,
   localparam int W_II   = calc_w_ii(W_DATA, FEATURE_WIDTH, FEATURE_HEIGHT),
   localparam int W_SQII = calc_w_sqii(W_DATA, FEATURE_WIDTH, FEATURE_HEIGHT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              din_valid,
   output logic              din_ready,
   input  logic [W_DATA-1:0] din_data,
   input  logic [1:0]        din_eot,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic [W_II-1:0]   dout_ii,
   output logic [W_SQII-1:0] dout_sqii,
   output logic [1:0]        dout_eot,
   output logic              err
);

   localparam int W_COL = (FEATURE_WIDTH > 1) ? $clog2(FEATURE_WIDTH) : 1;
   localparam int W_ROW = (FEATURE_HEIGHT > 1) ? $clog2(FEATURE_HEIGHT) : 1;
   localparam logic [W_COL-1:0] COL_LAST = W_COL'(FEATURE_WIDTH - 1);
   localparam logic [W_ROW-1:0] ROW_LAST = W_ROW'(FEATURE_HEIGHT - 1);

   row_state_e        state_q, state_d;
   logic              first_row;
   logic              accept;
   logic              frame_bad;
   logic [W_COL-1:0]  col_q;
   logic [W_ROW-1:0]  row_q;
   logic [W_II-1:0]   rowsum_q, rs, ii, buf_ii;
   logic [W_SQII-1:0] rowsq_q, rq, sq, buf_sq, p_sq;

   assign din_ready = !dout_valid | dout_ready;
   assign accept    = din_valid & din_ready;
   assign first_row = (state_q == FIRST_ROW);

   // Datapath: running row sum plus the column total from the row above.
   assign p_sq = W_SQII'(din_data) * W_SQII'(din_data);
   assign rs   = rowsum_q + W_II'(din_data);
   assign rq   = rowsq_q + p_sq;
   assign ii   = rs + (first_row ? '0 : buf_ii);
   assign sq   = rq + (first_row ? '0 : buf_sq);

   // A row that ends off the last column, reaches it without ending, or a
   // window that ends off the last row, is a framing error.
   assign frame_bad = (din_eot[EOT_ROW] && (col_q != COL_LAST)) ||
                      (!din_eot[EOT_ROW] && (col_q == COL_LAST)) ||
                      (din_eot[EOT_WIN] && (row_q != ROW_LAST));

   ii_row_buffer #(
      .DEPTH  (FEATURE_WIDTH),
      .W_II   (W_II),
      .W_SQII (W_SQII)
   ) u_row_buf (
      .clk   (clk),
      .idx   (col_q),
      .we    (accept),
      .wr_ii (ii),
      .wr_sq (sq),
      .rd_ii (buf_ii),
      .rd_sq (buf_sq)
   );

   // Row state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= FIRST_ROW;
      else      state_q <= state_d;
   end

   // Row state: end of window returns to first row, end of row leaves it.
   always_comb begin
      state_d = state_q;
      if (accept) begin
         if (din_eot[EOT_WIN])      state_d = FIRST_ROW;
         else if (din_eot[EOT_ROW]) state_d = OTHER_ROWS;
      end
   end

   // Column/row counters and row accumulators; they move only on accept and
   // always resynchronise to the incoming eot tags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_q    <= '0;
         row_q    <= '0;
         rowsum_q <= '0;
         rowsq_q  <= '0;
      end else if (accept) begin
         if (din_eot[EOT_WIN]) begin
            col_q    <= '0;
            row_q    <= '0;
            rowsum_q <= '0;
            rowsq_q  <= '0;
         end else if (din_eot[EOT_ROW]) begin
            col_q    <= '0;
            row_q    <= row_q + 1'b1;
            rowsum_q <= '0;
            rowsq_q  <= '0;
         end else begin
            col_q    <= (col_q == COL_LAST) ? '0 : col_q + 1'b1;
            rowsum_q <= rs;
            rowsq_q  <= rq;
         end
      end
   end

   // Output register: load on accept, drop valid once consumed, hold on stall.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dout_valid <= 1'b0;
         dout_ii    <= '0;
         dout_sqii  <= '0;
         dout_eot   <= '0;
      end else if (accept) begin
         dout_valid <= 1'b1;
         dout_ii    <= ii;
         dout_sqii  <= sq;
         dout_eot   <= din_eot;
      end else if (dout_ready) begin
         dout_valid <= 1'b0;
      end
   end

   // Sticky framing error, cleared only by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                       err <= 1'b0;
      else if (accept && frame_bad)   err <= 1'b1;
   end

endmodule

// File: tb/tb_window_integrator.sv
// Directed bench for window_integrator: integral values checked against a
// brute-force double-sum model and hand-computed constants.
module tb_window_integrator;

   localparam int FW = 24;
   localparam int FH = 24;
   localparam int NPIX = FW * FH;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        din_valid = 1'b0;
   logic        din_ready;
   logic [7:0]  din_data = '0;
   logic [1:0]  din_eot = '0;
   logic        dout_valid;
   logic        dout_ready = 1'b1;
   logic [17:0] dout_ii;
   logic [25:0] dout_sqii;
   logic [1:0]  dout_eot;
   logic        err;

   window_integrator #(.W_DATA(8), .FEATURE_WIDTH(FW), .FEATURE_HEIGHT(FH)) dut (
      .clk        (clk),
      .rst        (rst),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .din_data   (din_data),
      .din_eot    (din_eot),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout_ii    (dout_ii),
      .dout_sqii  (dout_sqii),
      .dout_eot   (dout_eot),
      .err        (err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int         pix [FH][FW];
   longint     exp_ii [FH][FW];
   longint     exp_sq [FH][FW];
   int         obs_ii [$];
   int         obs_sq [$];
   logic [1:0] obs_eot [$];

   bit          rand_ready = 1'b0;
   int          hold_viol = 0;
   int          hold_seen = 0;
   bit          hold_prev = 1'b0;
   logic [17:0] h_ii;
   logic [25:0] h_sq;
   logic [1:0]  h_eot;

   // Output monitor: records every transfer and watches stall stability.
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) begin
            hold_seen++;
            if (!dout_valid || dout_ii !== h_ii || dout_sqii !== h_sq || dout_eot !== h_eot)
               hold_viol++;
         end
         if (dout_valid && dout_ready) begin
            obs_ii.push_back(int'(dout_ii));
            obs_sq.push_back(int'(dout_sqii));
            obs_eot.push_back(dout_eot);
         end
         hold_prev = dout_valid && !dout_ready;
         h_ii  = dout_ii;
         h_sq  = dout_sqii;
         h_eot = dout_eot;
      end
   end

   // Downstream back-pressure generator.
   initial forever begin
      @(posedge clk);
      #1;
      if (rand_ready) dout_ready = 1'($urandom_range(0, 1));
   end

   task automatic clear_obs();
      obs_ii.delete();
      obs_sq.delete();
      obs_eot.delete();
   endtask

   // Brute-force model: explicit double sum over the window prefix.
   task automatic build_model();
      for (int y = 0; y < FH; y++)
         for (int x = 0; x < FW; x++) begin
            longint s = 0, q = 0;
            for (int i = 0; i <= y; i++)
               for (int j = 0; j <= x; j++) begin
                  s += pix[i][j];
                  q += pix[i][j] * pix[i][j];
               end
            exp_ii[y][x] = s;
            exp_sq[y][x] = q;
         end
   endtask

   // Present one pixel and wait (bounded) until it is accepted.
   task automatic send_pix(input int p, input logic [1:0] e, output bit ok);
      din_valid = 1'b1;
      din_data  = 8'(p);
      din_eot   = e;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (din_ready) ok = 1'b1;
      end
      @(posedge clk);
      #1;
      din_valid = 1'b0;
   endtask

   task automatic send_window(input bit gaps, output int tmo);
      bit ok;
      logic [1:0] e;
      tmo = 0;
      for (int y = 0; y < FH; y++)
         for (int x = 0; x < FW; x++) begin
            e[0] = (x == FW - 1);
            e[1] = (x == FW - 1) && (y == FH - 1);
            send_pix(pix[y][x], e, ok);
            if (!ok) tmo++;
            if (gaps && $urandom_range(0, 2) == 0) begin
               repeat ($urandom_range(1, 2)) @(posedge clk);
               #1;
            end
         end
   endtask

   task automatic wait_out(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 4000 && !ok; i++) begin
         if (obs_ii.size() >= n) ok = 1'b1;
         else @(negedge clk);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (dout_valid !== 1'b0 || dout_ii !== '0 || dout_sqii !== '0 || dout_eot !== 2'b00 || err !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%b ii=%0d sq=%0d eot=%b err=%b, want all 0",
                  dout_valid, dout_ii, dout_sqii, dout_eot, err);
      end
      checks++;
      if (din_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_din_ready: got %b want 1", din_ready);
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_ones();
      int tmo; bit ok;
      for (int y = 0; y < FH; y++) for (int x = 0; x < FW; x++) pix[y][x] = 1;
      clear_obs();
      send_window(1'b0, tmo);
      wait_out(NPIX, ok);
      checks++;
      if (tmo != 0 || !ok) begin
         errors++;
         $display("FAIL ones_flow: timeouts=%0d outputs=%0d, want 0 and %0d", tmo, obs_ii.size(), NPIX);
      end else begin
         for (int y = 0; y < FH; y++)
            for (int x = 0; x < FW; x++) begin
               int k = y * FW + x;
               logic [1:0] ee;
               ee[0] = (x == FW - 1);
               ee[1] = (x == FW - 1) && (y == FH - 1);
               checks++;
               if (obs_ii[k] != (x + 1) * (y + 1) || obs_sq[k] != (x + 1) * (y + 1) || obs_eot[k] !== ee) begin
                  errors++;
                  $display("FAIL ones_pixel(%0d,%0d): got ii=%0d sq=%0d eot=%b, want ii=sq=%0d eot=%b",
                           x, y, obs_ii[k], obs_sq[k], obs_eot[k], (x + 1) * (y + 1), ee);
               end
            end
         checks++;
         if (obs_ii[NPIX-1] != 576 || obs_sq[NPIX-1] != 576 || obs_eot[NPIX-1] !== 2'b11) begin
            errors++;
            $display("FAIL ones_last: got ii=%0d sq=%0d eot=%b, want 576 576 11",
                     obs_ii[NPIX-1], obs_sq[NPIX-1], obs_eot[NPIX-1]);
         end
      end
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL ones_err: got %b want 0", err);
      end
   endtask

   task automatic test_max();
      int tmo; bit ok;
      for (int y = 0; y < FH; y++) for (int x = 0; x < FW; x++) pix[y][x] = 255;
      build_model();
      clear_obs();
      send_window(1'b0, tmo);
      wait_out(NPIX, ok);
      checks++;
      if (tmo != 0 || !ok) begin
         errors++;
         $display("FAIL max_flow: timeouts=%0d outputs=%0d", tmo, obs_ii.size());
      end else begin
         checks++;
         if (obs_ii[NPIX-1] != 146880 || obs_sq[NPIX-1] != 37454400) begin
            errors++;
            $display("FAIL max_last: got ii=%0d sq=%0d, want 146880 37454400",
                     obs_ii[NPIX-1], obs_sq[NPIX-1]);
         end
         for (int y = 0; y < FH; y++)
            for (int x = 0; x < FW; x++) begin
               int k = y * FW + x;
               checks++;
               if (obs_ii[k] != exp_ii[y][x] || obs_sq[k] != exp_sq[y][x]) begin
                  errors++;
                  $display("FAIL max_pixel(%0d,%0d): got %0d/%0d want %0d/%0d",
                           x, y, obs_ii[k], obs_sq[k], exp_ii[y][x], exp_sq[y][x]);
               end
            end
      end
   endtask

   task automatic run_ramp(input bit stall, input string tag);
      int tmo; bit ok; int rows;
      for (int y = 0; y < FH; y++) for (int x = 0; x < FW; x++) pix[y][x] = x + y;
      build_model();
      clear_obs();
      rand_ready = stall;
      send_window(stall, tmo);
      wait_out(NPIX, ok);
      rand_ready = 1'b0;
      dout_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (tmo != 0 || !ok) begin
         errors++;
         $display("FAIL %s_flow: timeouts=%0d outputs=%0d", tag, tmo, obs_ii.size());
      end else begin
         rows = 0;
         for (int y = 0; y < FH; y++)
            for (int x = 0; x < FW; x++) begin
               int k = y * FW + x;
               if (obs_eot[k][0]) rows++;
               checks++;
               if (obs_ii[k] != exp_ii[y][x] || obs_sq[k] != exp_sq[y][x]) begin
                  errors++;
                  $display("FAIL %s_pixel(%0d,%0d): got %0d/%0d want %0d/%0d",
                           tag, x, y, obs_ii[k], obs_sq[k], exp_ii[y][x], exp_sq[y][x]);
               end
            end
         checks++;
         if (rows != FH || obs_ii.size() != NPIX) begin
            errors++;
            $display("FAIL %s_rows: got %0d row ends, %0d outputs, want %0d and %0d",
                     tag, rows, obs_ii.size(), FH, NPIX);
         end
      end
   endtask

   task automatic test_ramp();
      run_ramp(1'b0, "ramp");
   endtask

   task automatic test_stall();
      hold_viol = 0;
      hold_seen = 0;
      run_ramp(1'b1, "stall");
      checks++;
      if (hold_viol != 0 || hold_seen == 0) begin
         errors++;
         $display("FAIL stall_hold: got %0d unstable holds of %0d, want 0 of >0", hold_viol, hold_seen);
      end
   endtask

   task automatic test_back_to_back();
      int t1, t2; bit ok;
      clear_obs();
      for (int y = 0; y < FH; y++) for (int x = 0; x < FW; x++) pix[y][x] = 2;
      send_window(1'b0, t1);
      for (int y = 0; y < FH; y++) for (int x = 0; x < FW; x++) pix[y][x] = 3;
      send_window(1'b0, t2);
      wait_out(2 * NPIX, ok);
      checks++;
      if (t1 + t2 != 0 || !ok) begin
         errors++;
         $display("FAIL b2b_flow: timeouts=%0d outputs=%0d", t1 + t2, obs_ii.size());
      end else begin
         checks++;
         if (obs_ii[NPIX-1] != 1152 || obs_ii[NPIX] != 3 || obs_sq[NPIX] != 9) begin
            errors++;
            $display("FAIL b2b_boundary: got last1=%0d first2=%0d/%0d, want 1152 3/9",
                     obs_ii[NPIX-1], obs_ii[NPIX], obs_sq[NPIX]);
         end
         for (int y = 0; y < FH; y++)
            for (int x = 0; x < FW; x++) begin
               int k = NPIX + y * FW + x;
               checks++;
               if (obs_ii[k] != 3 * (x + 1) * (y + 1) || obs_sq[k] != 9 * (x + 1) * (y + 1)) begin
                  errors++;
                  $display("FAIL b2b_pixel(%0d,%0d): got %0d/%0d want %0d/%0d", x, y,
                           obs_ii[k], obs_sq[k], 3 * (x + 1) * (y + 1), 9 * (x + 1) * (y + 1));
               end
            end
      end
   endtask

   task automatic test_framing();
      bit ok; int tmo = 0;
      clear_obs();
      for (int x = 0; x < 10; x++) begin
         send_pix(1, 2'b00, ok);
         if (!ok) tmo++;
      end
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL frame_before: got err=%b want 0", err);
      end
      send_pix(1, 2'b01, ok);
      if (!ok) tmo++;
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL frame_err: got err=%b want 1", err);
      end
      for (int x = 0; x < 11; x++) begin
         send_pix(1, 2'b00, ok);
         if (!ok) tmo++;
      end
      wait_out(22, ok);
      checks++;
      if (tmo != 0 || !ok) begin
         errors++;
         $display("FAIL frame_flow: timeouts=%0d outputs=%0d", tmo, obs_ii.size());
      end else begin
         for (int x = 0; x < 11; x++) begin
            checks++;
            if (obs_ii[11 + x] != 2 * (x + 1) || obs_sq[11 + x] != 2 * (x + 1)) begin
               errors++;
               $display("FAIL frame_resync(x=%0d): got %0d/%0d want %0d",
                        x, obs_ii[11 + x], obs_sq[11 + x], 2 * (x + 1));
            end
         end
      end
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL frame_sticky: got err=%b want 1", err);
      end
   endtask

   task automatic test_reset_mid();
      bit ok; int tmo;
      for (int k = 0; k < 100; k++) begin
         send_pix(1, (k % FW == FW - 1) ? 2'b01 : 2'b00, ok);
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (dout_valid !== 1'b0 || dout_ii !== '0 || dout_sqii !== '0 || dout_eot !== 2'b00 || err !== 1'b0) begin
         errors++;
         $display("FAIL midreset_outputs: got v=%b ii=%0d sq=%0d eot=%b err=%b, want all 0",
                  dout_valid, dout_ii, dout_sqii, dout_eot, err);
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      clear_obs();
      for (int y = 0; y < FH; y++) for (int x = 0; x < FW; x++) pix[y][x] = 1;
      send_window(1'b0, tmo);
      wait_out(NPIX, ok);
      checks++;
      if (tmo != 0 || !ok) begin
         errors++;
         $display("FAIL midreset_flow: timeouts=%0d outputs=%0d", tmo, obs_ii.size());
      end else begin
         for (int y = 0; y < FH; y++)
            for (int x = 0; x < FW; x++) begin
               int k = y * FW + x;
               checks++;
               if (obs_ii[k] != (x + 1) * (y + 1) || obs_sq[k] != (x + 1) * (y + 1)) begin
                  errors++;
                  $display("FAIL midreset_pixel(%0d,%0d): got %0d/%0d want %0d",
                           x, y, obs_ii[k], obs_sq[k], (x + 1) * (y + 1));
               end
            end
      end
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL midreset_err: got %b want 0", err);
      end
   endtask

   initial begin
      test_reset();
      test_ones();
      test_max();
      test_ramp();
      test_stall();
      test_back_to_back();
      test_framing();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
